// File: rtl/dsp_sample_bridge.sv
// Two-way bridge between the DSP sample path and the CSR side: a capture FIFO fed by the
// downsampler strobe and drained by software, and a playback FIFO that feeds the upsampler.
module dsp_sample_bridge #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ds_data,
  input  logic              ds_strobe,
  input  logic              cap_enable,
  input  logic              cap_rd_en,
  output logic [DATA_W-1:0] cap_rd_data,
  output logic [AW:0]       cap_level,
  output logic              cap_overflow,
  input  logic              us_strobe,
  input  logic              pb_enable,
  input  logic              pb_wr_en,
  input  logic [DATA_W-1:0] pb_wr_data,
  output logic [AW:0]       pb_level,
  output logic              pb_wr_drop,
  output logic              pb_underrun,
  output logic [DATA_W-1:0] us_data,
  input  logic              clr_flags
);

  localparam logic [AW:0] PtrOne = 1;

  // Capture side
  logic [DATA_W-1:0] cap_mem [DEPTH];
  logic [AW:0]       cap_wr_ptr_q, cap_rd_ptr_q, cap_level_q;
  logic [DATA_W-1:0] cap_rd_data_q;
  logic              cap_overflow_q;
  logic              cap_full, cap_empty, cap_push, cap_pop, cap_ovf_set;

  assign cap_empty   = (cap_wr_ptr_q == cap_rd_ptr_q);
  assign cap_full    = (cap_wr_ptr_q[AW] != cap_rd_ptr_q[AW]) &&
                       (cap_wr_ptr_q[AW-1:0] == cap_rd_ptr_q[AW-1:0]);
  assign cap_pop     = cap_rd_en & ~cap_empty;
  assign cap_push    = ds_strobe & cap_enable & (~cap_full | cap_pop);
  assign cap_ovf_set = ds_strobe & cap_enable & cap_full & ~cap_pop;

  always_ff @(posedge sys_clk) begin
    if (cap_push) cap_mem[cap_wr_ptr_q[AW-1:0]] <= ds_data;
  end

  // Level and head are registered copies of the pointer state, giving one cycle of latency.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_wr_ptr_q   <= '0;
      cap_rd_ptr_q   <= '0;
      cap_level_q    <= '0;
      cap_rd_data_q  <= '0;
      cap_overflow_q <= 1'b0;
    end else begin
      if (cap_push) cap_wr_ptr_q <= cap_wr_ptr_q + PtrOne;
      if (cap_pop)  cap_rd_ptr_q <= cap_rd_ptr_q + PtrOne;
      cap_level_q    <= cap_wr_ptr_q - cap_rd_ptr_q;
      cap_rd_data_q  <= cap_empty ? '0 : cap_mem[cap_rd_ptr_q[AW-1:0]];
      cap_overflow_q <= cap_ovf_set | (cap_overflow_q & ~clr_flags);
    end
  end

  assign cap_rd_data  = cap_rd_data_q;
  assign cap_level    = cap_level_q;
  assign cap_overflow = cap_overflow_q;

  // Playback side
  logic [DATA_W-1:0] pb_mem [DEPTH];
  logic [AW:0]       pb_wr_ptr_q, pb_rd_ptr_q;
  logic [DATA_W-1:0] us_data_q;
  logic              pb_wr_drop_q, pb_underrun_q;
  logic              pb_full, pb_empty, pb_push, pb_pop, pb_drop_set, pb_unr_set;

  assign pb_empty    = (pb_wr_ptr_q == pb_rd_ptr_q);
  assign pb_full     = (pb_wr_ptr_q[AW] != pb_rd_ptr_q[AW]) &&
                       (pb_wr_ptr_q[AW-1:0] == pb_rd_ptr_q[AW-1:0]);
  assign pb_pop      = us_strobe & pb_enable & ~pb_empty;
  assign pb_push     = pb_wr_en & (~pb_full | pb_pop);
  assign pb_drop_set = pb_wr_en & pb_full & ~pb_pop;
  assign pb_unr_set  = us_strobe & pb_enable & pb_empty;

  always_ff @(posedge sys_clk) begin
    if (pb_push) pb_mem[pb_wr_ptr_q[AW-1:0]] <= pb_wr_data;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_wr_ptr_q   <= '0;
      pb_rd_ptr_q   <= '0;
      us_data_q     <= '0;
      pb_wr_drop_q  <= 1'b0;
      pb_underrun_q <= 1'b0;
    end else begin
      if (pb_push) pb_wr_ptr_q <= pb_wr_ptr_q + PtrOne;
      if (pb_pop)  pb_rd_ptr_q <= pb_rd_ptr_q + PtrOne;
      // Disabled or starved strobes drive silence rather than repeating the last sample.
      if (us_strobe) us_data_q <= pb_pop ? pb_mem[pb_rd_ptr_q[AW-1:0]] : '0;
      pb_wr_drop_q  <= pb_drop_set | (pb_wr_drop_q & ~clr_flags);
      pb_underrun_q <= pb_unr_set | (pb_underrun_q & ~clr_flags);
    end
  end

  assign pb_level    = pb_wr_ptr_q - pb_rd_ptr_q;
  assign us_data     = us_data_q;
  assign pb_wr_drop  = pb_wr_drop_q;
  assign pb_underrun = pb_underrun_q;

endmodule

// File: tb/tb_dsp_sample_bridge.sv
// Directed-vector bench for dsp_sample_bridge at DATA_W=16, DEPTH=16.
module tb_dsp_sample_bridge;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ds_data = '0;
  logic        ds_strobe = 1'b0;
  logic        cap_enable = 1'b0;
  logic        cap_rd_en = 1'b0;
  logic [15:0] cap_rd_data;
  logic [4:0]  cap_level;
  logic        cap_overflow;
  logic        us_strobe = 1'b0;
  logic        pb_enable = 1'b0;
  logic        pb_wr_en = 1'b0;
  logic [15:0] pb_wr_data = '0;
  logic [4:0]  pb_level;
  logic        pb_wr_drop;
  logic        pb_underrun;
  logic [15:0] us_data;
  logic        clr_flags = 1'b0;

  int checks = 0;
  int failures = 0;

  dsp_sample_bridge #(.DATA_W(16), .DEPTH(16)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .ds_data(ds_data), .ds_strobe(ds_strobe),
    .cap_enable(cap_enable), .cap_rd_en(cap_rd_en), .cap_rd_data(cap_rd_data),
    .cap_level(cap_level), .cap_overflow(cap_overflow), .us_strobe(us_strobe),
    .pb_enable(pb_enable), .pb_wr_en(pb_wr_en), .pb_wr_data(pb_wr_data),
    .pb_level(pb_level), .pb_wr_drop(pb_wr_drop), .pb_underrun(pb_underrun),
    .us_data(us_data), .clr_flags(clr_flags)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ds_push(input logic [15:0] v);
    ds_data = v; ds_strobe = 1'b1;
    tick();
    ds_strobe = 1'b0;
  endtask

  // Pop, then one idle cycle so the next head is on cap_rd_data.
  task automatic cap_pop();
    cap_rd_en = 1'b1;
    tick();
    cap_rd_en = 1'b0;
    tick();
  endtask

  task automatic pb_push(input logic [15:0] v);
    pb_wr_data = v; pb_wr_en = 1'b1;
    tick();
    pb_wr_en = 1'b0;
  endtask

  task automatic us_pulse();
    us_strobe = 1'b1;
    tick();
    us_strobe = 1'b0;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (cap_level !== 5'd0) begin failures++; $display("FAIL reset_cap_level got=%0d exp=0", cap_level); end
    checks++; if (pb_level !== 5'd0) begin failures++; $display("FAIL reset_pb_level got=%0d exp=0", pb_level); end
    checks++; if (cap_rd_data !== 16'h0) begin failures++; $display("FAIL reset_cap_rd_data got=%h exp=0000", cap_rd_data); end
    checks++; if (us_data !== 16'h0) begin failures++; $display("FAIL reset_us_data got=%h exp=0000", us_data); end
    checks++;
    if ({cap_overflow, pb_wr_drop, pb_underrun} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {cap_overflow, pb_wr_drop, pb_underrun});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_capture_basic();
    logic [15:0] exp [3];
    exp[0] = 16'h8000; exp[1] = 16'h7FFF; exp[2] = 16'h0000;
    cap_enable = 1'b1;
    ds_push(16'h0001); ds_push(16'h8000); ds_push(16'h7FFF);
    tick();
    checks++; if (cap_level !== 5'd3) begin failures++; $display("FAIL cap_basic_level got=%0d exp=3", cap_level); end
    checks++; if (cap_rd_data !== 16'h0001) begin failures++; $display("FAIL cap_basic_head got=%h exp=0001", cap_rd_data); end
    for (int i = 0; i < 3; i++) begin
      cap_pop();
      checks++;
      if (cap_rd_data !== exp[i]) begin
        failures++; $display("FAIL cap_basic_pop%0d got=%h exp=%h", i, cap_rd_data, exp[i]);
      end
    end
    checks++; if (cap_level !== 5'd0) begin failures++; $display("FAIL cap_basic_empty got=%0d exp=0", cap_level); end
    checks++; if (cap_overflow !== 1'b0) begin failures++; $display("FAIL cap_basic_ovf got=%b exp=0", cap_overflow); end
  endtask

  task automatic test_capture_overflow();
    for (int i = 0; i < 17; i++) ds_push(16'(i));
    tick();
    checks++; if (cap_level !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d exp=16", cap_level); end
    checks++; if (cap_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", cap_overflow); end
    // Another dropped sample coinciding with clr_flags: the set must win.
    ds_data = 16'd17; ds_strobe = 1'b1; clr_flags = 1'b1;
    tick();
    ds_strobe = 1'b0; clr_flags = 1'b0;
    checks++; if (cap_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", cap_overflow); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_rd_data !== 16'(i)) begin
        failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, cap_rd_data, 16'(i));
      end
      cap_pop();
    end
    checks++; if (cap_level !== 5'd0) begin failures++; $display("FAIL ovf_drained got=%0d exp=0", cap_level); end
    checks++; if (cap_rd_data !== 16'h0) begin failures++; $display("FAIL ovf_empty_data got=%h exp=0000", cap_rd_data); end
    clear_flags();
    checks++; if (cap_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", cap_overflow); end
  endtask

  task automatic test_capture_full_push_pop();
    for (int i = 0; i < 16; i++) ds_push(16'h0020 + 16'(i));
    tick();
    checks++; if (cap_level !== 5'd16) begin failures++; $display("FAIL fpp_full got=%0d exp=16", cap_level); end
    ds_data = 16'h0099; ds_strobe = 1'b1; cap_rd_en = 1'b1;
    tick();
    ds_strobe = 1'b0; cap_rd_en = 1'b0;
    tick();
    checks++; if (cap_level !== 5'd16) begin failures++; $display("FAIL fpp_level got=%0d exp=16", cap_level); end
    checks++; if (cap_overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%b exp=0", cap_overflow); end
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (cap_rd_data !== 16'h0020 + 16'(i)) begin
        failures++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, cap_rd_data, 16'h0020 + 16'(i));
      end
      cap_pop();
    end
    checks++; if (cap_rd_data !== 16'h0099) begin failures++; $display("FAIL fpp_last got=%h exp=0099", cap_rd_data); end
    cap_pop();
    checks++; if (cap_level !== 5'd0) begin failures++; $display("FAIL fpp_empty got=%0d exp=0", cap_level); end
  endtask

  task automatic test_playback_basic();
    pb_push(16'h1234); pb_push(16'hFEDC);
    checks++; if (pb_level !== 5'd2) begin failures++; $display("FAIL pb_basic_level got=%0d exp=2", pb_level); end
    pb_enable = 1'b1;
    us_pulse();
    checks++; if (us_data !== 16'h1234) begin failures++; $display("FAIL pb_basic_s1 got=%h exp=1234", us_data); end
    repeat (9) tick();
    checks++; if (us_data !== 16'h1234) begin failures++; $display("FAIL pb_basic_hold got=%h exp=1234", us_data); end
    us_pulse();
    checks++; if (us_data !== 16'hFEDC) begin failures++; $display("FAIL pb_basic_s2 got=%h exp=fedc", us_data); end
    checks++; if (pb_underrun !== 1'b0) begin failures++; $display("FAIL pb_basic_unr_early got=%b exp=0", pb_underrun); end
    repeat (9) tick();
    us_pulse();
    checks++; if (us_data !== 16'h0000) begin failures++; $display("FAIL pb_basic_s3 got=%h exp=0000", us_data); end
    checks++; if (pb_underrun !== 1'b1) begin failures++; $display("FAIL pb_basic_unr got=%b exp=1", pb_underrun); end
    clear_flags();
    checks++; if (pb_underrun !== 1'b0) begin failures++; $display("FAIL pb_basic_clr got=%b exp=0", pb_underrun); end
  endtask

  task automatic test_playback_wrap();
    logic [15:0] q [$];
    logic [15:0] exp_v;
    logic        do_pop;
    int          n = 0;
    for (int i = 0; i < 40; i++) begin
      do_pop = (i % 2 == 1) && (q.size() > 0);
      pb_wr_en = (i % 4 != 3); pb_wr_data = 16'h1000 + 16'(n); us_strobe = do_pop;
      tick();
      pb_wr_en = 1'b0; us_strobe = 1'b0;
      if (do_pop) exp_v = q.pop_front();
      if (i % 4 != 3) begin q.push_back(16'h1000 + 16'(n)); n++; end
      checks++;
      if (pb_level !== 5'(q.size())) begin
        failures++; $display("FAIL wrap_level%0d got=%0d exp=%0d", i, pb_level, q.size());
      end
      if (do_pop) begin
        checks++;
        if (us_data !== exp_v) begin failures++; $display("FAIL wrap_data%0d got=%h exp=%h", i, us_data, exp_v); end
      end
    end
    while (q.size() < 16) begin
      pb_push(16'h1000 + 16'(n)); q.push_back(16'h1000 + 16'(n)); n++;
      checks++;
      if (pb_level !== 5'(q.size())) begin
        failures++; $display("FAIL fill_level got=%0d exp=%0d", pb_level, q.size());
      end
    end
    checks++; if (pb_wr_drop !== 1'b0) begin failures++; $display("FAIL drop_early got=%b exp=0", pb_wr_drop); end
    pb_push(16'hDEAD);
    checks++; if (pb_wr_drop !== 1'b1) begin failures++; $display("FAIL drop_flag got=%b exp=1", pb_wr_drop); end
    checks++; if (pb_level !== 5'd16) begin failures++; $display("FAIL drop_level got=%0d exp=16", pb_level); end
    while (q.size() > 0) begin
      exp_v = q.pop_front();
      us_pulse();
      checks++;
      if (us_data !== exp_v) begin failures++; $display("FAIL drain_data got=%h exp=%h", us_data, exp_v); end
    end
    checks++; if (pb_level !== 5'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", pb_level); end
    checks++; if (pb_underrun !== 1'b0) begin failures++; $display("FAIL wrap_unr got=%b exp=0", pb_underrun); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) begin
      ds_push(16'h2000 + 16'(i));
      pb_push(16'h3000 + 16'(i));
    end
    us_pulse();
    checks++; if (cap_level !== 5'd8) begin failures++; $display("FAIL ar_pre_cap got=%0d exp=8", cap_level); end
    checks++; if (us_data !== 16'h3000) begin failures++; $display("FAIL ar_pre_us got=%h exp=3000", us_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cap_level !== 5'd0) begin failures++; $display("FAIL ar_cap_level got=%0d exp=0", cap_level); end
    checks++; if (pb_level !== 5'd0) begin failures++; $display("FAIL ar_pb_level got=%0d exp=0", pb_level); end
    checks++; if (cap_rd_data !== 16'h0) begin failures++; $display("FAIL ar_cap_data got=%h exp=0000", cap_rd_data); end
    checks++; if (us_data !== 16'h0) begin failures++; $display("FAIL ar_us_data got=%h exp=0000", us_data); end
    checks++;
    if ({cap_overflow, pb_wr_drop, pb_underrun} !== 3'b000) begin
      failures++; $display("FAIL ar_flags got=%b exp=000", {cap_overflow, pb_wr_drop, pb_underrun});
    end
    tick();
    rst_n = 1'b1;
    tick();
    ds_push(16'h0055);
    tick();
    checks++; if (cap_level !== 5'd1) begin failures++; $display("FAIL ar_resume_level got=%0d exp=1", cap_level); end
    checks++; if (cap_rd_data !== 16'h0055) begin failures++; $display("FAIL ar_resume_data got=%h exp=0055", cap_rd_data); end
    pb_push(16'h0066);
    us_pulse();
    checks++; if (us_data !== 16'h0066) begin failures++; $display("FAIL ar_resume_us got=%h exp=0066", us_data); end
  endtask

  initial begin
    test_reset();
    test_capture_basic();
    test_capture_overflow();
    test_capture_full_push_pop();
    test_playback_basic();
    test_playback_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_sample_bridge.md
Name: dsp_sample_bridge

Overview:
Bridges the fixed-rate DSP sample path and the SoC CSR/bus side, in both directions.
- Capture: buffers each decimated sample (downsampler output, qualified by its ce_out strobe) into a capture FIFO that software drains.
- Playback: buffers software-written samples and presents them one per upsampler-rate strobe on the upsampler input.
- Overflow and underrun conditions are flagged with sticky bits.

Parameters:
DATA_W, 16, sample width in bits (signed two's complement, passed through unmodified)
DEPTH, 16, entries per FIFO; power of two, at least 2
AW, log2(DEPTH), FIFO address width (derived, not overridden)

Ports:
sys_clk  in  1  single clock for all logic
rst_n  in  1  reset, asynchronous assert, active-low
ds_data  in  DATA_W  decimated sample from the downsampler
ds_strobe  in  1  one-cycle pulse; ds_data valid this cycle
cap_enable  in  1  capture enable
cap_rd_en  in  1  software pop request, capture FIFO
cap_rd_data  out  DATA_W  head of capture FIFO (first-word fall-through)
cap_level  out  AW+1  capture FIFO occupancy, 0..DEPTH
cap_overflow  out  1  sticky: sample dropped because capture FIFO was full
us_strobe  in  1  one-cycle pulse; upsampler consumes its next input
pb_enable  in  1  playback enable
pb_wr_en  in  1  software push request, playback FIFO
pb_wr_data  in  DATA_W  sample to push
pb_level  out  AW+1  playback FIFO occupancy, 0..DEPTH
pb_wr_drop  out  1  sticky: push ignored because playback FIFO was full
pb_underrun  out  1  sticky: us_strobe arrived with playback FIFO empty while enabled
us_data  out  DATA_W  registered sample driven to the upsampler input
clr_flags  in  1  one-cycle pulse; clears all three sticky flags

Behaviour:
Reset (rst_n low, asynchronous):
- Both FIFOs empty; pointers 0; levels 0.
- cap_rd_data = 0, us_data = 0, all sticky flags = 0.
- Reset asserted mid-operation discards FIFO contents immediately.

Capture FIFO:
- Write when ds_strobe & cap_enable & (not full, or cap_rd_en in the same cycle).
- ds_strobe & cap_enable while full with no pop: sample dropped; cap_overflow set next cycle.
- ds_strobe with cap_enable low: ignored, no flag.
- Pop when cap_rd_en & not empty. cap_rd_en when empty: no effect, no flag.
- Push and pop in the same cycle: level unchanged.
- cap_rd_data: registered copy of the head entry; 0 when empty.
- Latency: sample written at edge N is visible on cap_rd_data and counted in cap_level after edge N+1 (one-cycle latency).
- After a pop, cap_rd_data shows the next entry one cycle later.

Playback FIFO:
- Push when pb_wr_en & (not full, or a pop occurs in the same cycle).
- pb_wr_en while full with no pop: write dropped; pb_wr_drop set.

us_data update rules, applied on the edge following the us_strobe cycle:
- pb_enable high and FIFO not empty: us_data <= head; pop.
- pb_enable high and FIFO empty: us_data <= 0; pb_underrun set.
- pb_enable low: us_data <= 0; FIFO untouched; no flag.
- Without us_strobe, us_data holds its value. It never changes between strobes.

Pointers and levels:
- Read and write pointers are AW+1 bits and wrap modulo 2*DEPTH.
- full = (MSBs differ) & (lower AW bits equal); empty = pointers equal.
- Level = wr_ptr - rd_ptr (modulo arithmetic), correct across wrap.

Flags:
- clr_flags clears all sticky flags.
- If a set event and clr_flags occur in the same cycle, the set wins: flag reads 1.

Arithmetic:
- No scaling, saturation or sign conversion; samples pass bit-exact.

Strobe independence:
- ds_strobe and us_strobe are independent and may coincide with each other and with software accesses.
- All four FIFO operations (both push/pop pairs) complete in one cycle with no stalls.

Test Plan:
1. Reset; cap_enable=1; 3 ds_strobe pulses with 0x0001, 0x8000, 0x7FFF -> cap_level=3; three pops return 0x0001, 0x8000, 0x7FFF in order; cap_rd_data=0 afterwards; cap_overflow=0.
2. DEPTH=16; 17 strobes with values 0..16, no pops -> cap_level=16; cap_overflow=1; pops return 0..15 (16 lost); clr_flags -> cap_overflow=0.
3. Capture FIFO full; ds_strobe and cap_rd_en in the same cycle -> level stays 16; no overflow; new sample appears as the last entry.
4. Push 0x1234, 0xFEDC; pb_enable=1; 3 us_strobe pulses spaced 10 cycles -> us_data = 0x1234, then 0xFEDC, then 0x0000, each one cycle after its strobe; pb_underrun=1 only after the third strobe.
5. Playback: 40 push/pop cycles interleaved across pointer wrap; pb_level checked every cycle against a model -> never exceeds 16; data order preserved; 17th push into a full FIFO sets pb_wr_drop.
6. Assert rst_n low mid-stream with both FIFOs half full -> levels, data outputs and flags read 0 immediately (asynchronous); normal operation resumes after release.
